// File: rtl/nts_tx_arbiter.sv
// Round-robin scheduler draining per-engine NTS Tx buffers into one MAC Tx port.
// Define NTS_TX_ARB_STRICT_PRIORITY_EN for fixed lowest-index-wins arbitration.
module nts_tx_arbiter #(
   parameter int unsigned ENGINES   = 2,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic                    i_clk,
   input  logic                    i_areset_n,
   input  logic [ENGINES-1:0]      i_engine_packet_available,
   input  logic [ENGINES-1:0]      i_engine_fifo_empty,
   output logic [ENGINES-1:0]      o_engine_fifo_rd_en,
   input  logic [64*ENGINES-1:0]   i_engine_fifo_rd_data,
   input  logic [4*ENGINES-1:0]    i_engine_bytes_last_word,
   output logic [ENGINES-1:0]      o_engine_packet_read,
   output logic                    o_mac_tx_valid,
   input  logic                    i_mac_tx_ready,
   output logic [63:0]             o_mac_tx_data,
   output logic [7:0]              o_mac_tx_bytes,
   output logic                    o_mac_tx_last,
   output logic                    o_mac_tx_abort,
   output logic                    o_error,
   output logic                    o_busy
);

   localparam int unsigned SEL_W = (ENGINES > 1) ? $clog2(ENGINES) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CAPTURE = 3'd2,
      S_SEND    = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ENGINES-1:0] rd_en_q, rd_en_d;
   logic [ENGINES-1:0] pkt_read_q, pkt_read_d;
   logic               valid_q, valid_d;
   logic [63:0]        data_q, data_d;
   logic [7:0]         bytes_q, bytes_d;
   logic               last_q, last_d;
   logic               abort_q, abort_d;
   logic               error_q, error_d;
   logic               busy_q, busy_d;

   logic               scan_hit;
   logic [SEL_W-1:0]   scan_sel;
   logic [SEL_W-1:0]   mux_sel;
   logic               empty_m;
   logic [63:0]        data_m;
   logic [3:0]         bytes_m;
   logic               bytes_bad;

   // Top-N byte mask for the final word; out-of-range counts mean a full word.
   function automatic logic [7:0] last_mask(input logic [3:0] n);
      logic [7:0] m;
      m = 8'hFF;
      if (n != 4'd0 && n <= 4'd8) begin
         m = 8'hFF << (4'd8 - n);
      end
      return m;
   endfunction

   // First available engine at or above the pointer, else the first one below it.
   always_comb begin
      scan_hit = 1'b0;
      scan_sel = '0;
      for (int j = 0; j < ENGINES; j++) begin
         if (!scan_hit && i_engine_packet_available[j] && (SEL_W'(j) >= ptr_q)) begin
            scan_hit = 1'b1;
            scan_sel = SEL_W'(j);
         end
      end
      for (int j = 0; j < ENGINES; j++) begin
         if (!scan_hit && i_engine_packet_available[j]) begin
            scan_hit = 1'b1;
            scan_sel = SEL_W'(j);
         end
      end
   end

   // Per-engine input mux; in IDLE it follows the candidate so empty can be checked early.
   always_comb begin
      mux_sel = (state_q == S_IDLE) ? scan_sel : sel_q;
      empty_m = 1'b1;
      data_m  = '0;
      bytes_m = '0;
      for (int j = 0; j < ENGINES; j++) begin
         if (SEL_W'(j) == mux_sel) begin
            empty_m = i_engine_fifo_empty[j];
            data_m  = i_engine_fifo_rd_data[64*j +: 64];
            bytes_m = i_engine_bytes_last_word[4*j +: 4];
         end
      end
      bytes_bad = (bytes_m == 4'd0) || (bytes_m > 4'd8);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      bytes_d    = bytes_q;
      last_d     = last_q;
      abort_d    = abort_q;
      error_d    = 1'b0;
      rd_en_d    = '0;
      pkt_read_d = '0;

      unique case (state_q)
         S_IDLE: begin
            if (scan_hit) begin
               sel_d = scan_sel;
               if (empty_m) begin
                  state_d = S_DONE;
                  error_d = 1'b1;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            data_d  = data_m;
            last_d  = empty_m;
            abort_d = 1'b0;
            bytes_d = 8'hFF;
            if (empty_m) begin
               bytes_d = last_mask(bytes_m);
               error_d = bytes_bad;
            end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
               last_d  = 1'b1;
               abort_d = 1'b1;
            end
            state_d = S_SEND;
         end
         S_SEND: begin
            if (i_mac_tx_ready) begin
               state_d = last_q ? S_DONE : S_READ;
               error_d = last_q && abort_q;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            data_d  = '0;
            bytes_d = '0;
            last_d  = 1'b0;
            abort_d = 1'b0;
`ifdef NTS_TX_ARB_STRICT_PRIORITY_EN
            ptr_d   = ptr_q;
`else
            ptr_d   = ((32'(sel_q) + 32'd1) >= ENGINES) ? '0 : sel_q + SEL_W'(1);
`endif
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      for (int j = 0; j < ENGINES; j++) begin
         rd_en_d[j]    = (state_d == S_READ) && (SEL_W'(j) == sel_d);
         pkt_read_d[j] = (state_d == S_DONE) && (SEL_W'(j) == sel_d);
      end
      valid_d = (state_d == S_SEND);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         sel_q      <= '0;
         cnt_q      <= '0;
         rd_en_q    <= '0;
         pkt_read_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         bytes_q    <= '0;
         last_q     <= 1'b0;
         abort_q    <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         rd_en_q    <= rd_en_d;
         pkt_read_q <= pkt_read_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         bytes_q    <= bytes_d;
         last_q     <= last_d;
         abort_q    <= abort_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
      end
   end

   assign o_engine_fifo_rd_en  = rd_en_q;
   assign o_engine_packet_read = pkt_read_q;
   assign o_mac_tx_valid       = valid_q;
   assign o_mac_tx_data        = data_q;
   assign o_mac_tx_bytes       = bytes_q;
   assign o_mac_tx_last        = last_q;
   assign o_mac_tx_abort       = abort_q;
   assign o_error              = error_q;
   assign o_busy               = busy_q;

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Scoreboard bench for nts_tx_arbiter: engine FIFO models, MAC sink, release tracking.
module tb_nts_tx_arbiter;

   localparam int unsigned ENG  = 2;
   localparam int unsigned MAXW = 4;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  m;
      logic        l;
      logic        a;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ENG-1:0]    avail;
   logic [ENG-1:0]    empty;
   logic [ENG-1:0]    rd_en;
   logic [64*ENG-1:0] rdd;
   logic [4*ENG-1:0]  blw;
   logic [ENG-1:0]    pkt_read;
   logic              valid;
   logic              ready;
   logic [63:0]       data;
   logic [7:0]        bytes;
   logic              last;
   logic              abort;
   logic              error;
   logic              busy;

   // Engine buffer model state
   logic [63:0] mem       [ENG][64];
   int          wr_n      [ENG];
   int          pk_start  [ENG][16];
   int          pk_end    [ENG][16];
   logic [3:0]  pk_bytes  [ENG][16];
   int          pk_loaded [ENG];
   int          pk_rel    [ENG] = '{0, 0};
   int          rd_ptr    [ENG] = '{0, 0};
   logic [63:0] rd_data_r [ENG];

   exp_t exp_q[$];
   int   rel_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_reads = 0;
   int   exp_err   = 0;
   int   rd_pulses = 0;
   int   err_seen  = 0;
   bit   stalled   = 1'b0;
   logic [73:0] held;

   nts_tx_arbiter #(.ENGINES(ENG), .MAX_WORDS(MAXW)) dut (
      .i_clk                     (clk),
      .i_areset_n                (rst_n),
      .i_engine_packet_available (avail),
      .i_engine_fifo_empty       (empty),
      .o_engine_fifo_rd_en       (rd_en),
      .i_engine_fifo_rd_data     (rdd),
      .i_engine_bytes_last_word  (blw),
      .o_engine_packet_read      (pkt_read),
      .o_mac_tx_valid            (valid),
      .i_mac_tx_ready            (ready),
      .o_mac_tx_data             (data),
      .o_mac_tx_bytes            (bytes),
      .o_mac_tx_last             (last),
      .o_mac_tx_abort            (abort),
      .o_error                   (error),
      .o_busy                    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input int e, input int pid, input int w);
      return {8'(e), 8'(pid), 16'hBEEF, 32'(w)};
   endfunction

   function automatic logic [7:0] mask_of(input logic [3:0] nb);
      logic [7:0] m;
      int n;
      n = (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
      for (int b = 0; b < 8; b++) m[7-b] = (b < n);
      return m;
   endfunction

   // Combinational view of each engine's current packet
   always_comb begin
      for (int e = 0; e < ENG; e++) begin
         avail[e]       = (pk_rel[e] != pk_loaded[e]);
         empty[e]       = !avail[e] || (rd_ptr[e] >= pk_end[e][pk_rel[e]]);
         blw[4*e +: 4]  = avail[e] ? pk_bytes[e][pk_rel[e]] : 4'd0;
         rdd[64*e +: 64] = rd_data_r[e];
      end
   end

   // FIFO read latency of one cycle; release flushes the rest; reset rewinds the packet.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < ENG; e++) begin
            rd_ptr[e]    <= (pk_rel[e] < pk_loaded[e]) ? pk_start[e][pk_rel[e]] : wr_n[e];
            rd_data_r[e] <= '0;
         end
      end else begin
         for (int e = 0; e < ENG; e++) begin
            if (rd_en[e]) begin
               rd_data_r[e] <= (rd_ptr[e] < 64) ? mem[e][rd_ptr[e]] : 64'hDEAD;
               rd_ptr[e]    <= rd_ptr[e] + 1;
            end
            if (pkt_read[e]) begin
               rd_ptr[e] <= pk_end[e][pk_rel[e]];
               pk_rel[e] <= pk_rel[e] + 1;
            end
         end
      end
   end

   // MAC sink / release monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) check("stall_hold", {valid, data, bytes, last, abort}, {1'b1, held});
         stalled = valid && !ready;
         held    = {data, bytes, last, abort};
         if (valid && ready) begin
            if (exp_q.size() == 0) check("mac_unexpected", 1, 0);
            else check("mac_word", {data, bytes, last, abort}, exp_q.pop_front());
         end
         if (pkt_read != '0) begin
            if (rel_q.size() == 0) check("release_unexpected", 1, 0);
            else check("release", pkt_read, 96'(1) << rel_q.pop_front());
         end
         if (rd_en != '0) begin
            rd_pulses++;
            if (!$onehot(rd_en)) check("rd_en_onehot", rd_en, 0);
         end
         if (error) err_seen++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load_pkt(input int e, input int pid, input int nwords, input logic [3:0] nb);
      int k;
      k = pk_loaded[e];
      pk_start[e][k] = wr_n[e];
      for (int w = 0; w < nwords; w++) mem[e][wr_n[e] + w] = word_of(e, pid, w);
      wr_n[e]        = wr_n[e] + nwords;
      pk_end[e][k]   = wr_n[e];
      pk_bytes[e][k] = nb;
      pk_loaded[e]   = k + 1;
   endtask

   task automatic exp_pkt(input int e, input int pid, input int nwords, input logic [3:0] nb);
      exp_t it;
      int nsend;
      nsend = (nwords > int'(MAXW)) ? int'(MAXW) : nwords;
      for (int w = 0; w < nsend; w++) begin
         it.d = word_of(e, pid, w);
         it.l = (w == nwords - 1) || (w == int'(MAXW) - 1);
         it.a = (nwords > int'(MAXW)) && (w == int'(MAXW) - 1);
         it.m = (w == nwords - 1) ? mask_of(nb) : 8'hFF;
         exp_q.push_back(it);
      end
      rel_q.push_back(e);
      exp_reads += nsend;
      if (nwords == 0 || nwords > int'(MAXW)) exp_err++;
      else if (nb == 4'd0 || nb > 4'd8) exp_err++;
   endtask

   task automatic wait_drain(input string tag, input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (exp_q.size() == 0 && rel_q.size() == 0 && !busy && avail == '0) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      check({tag, "_drain"}, 96'(ok), 1);
   endtask

   task automatic wait_valid(input string tag, input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (valid) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      check({tag, "_valid"}, 96'(ok), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int e = 0; e < ENG; e++) begin
         wr_n[e] = 0;
         pk_loaded[e] = 0;
         for (int k = 0; k < 16; k++) begin
            pk_start[e][k] = 0;
            pk_end[e][k]   = 0;
            pk_bytes[e][k] = 4'd0;
         end
      end
      rst_n = 1'b1;
      ready = 1'b1;
      #1 rst_n = 1'b0;
      step(2);
      check("reset_state", {rd_en, pkt_read, valid, data, bytes, last, abort, error, busy}, 0);
      rst_n = 1'b1;
      step(2);

      // 3-word packet, 5 valid bytes in last word, 10 busy cycles
      exp_pkt(0, 1, 3, 4'd5);
      load_pkt(0, 1, 3, 4'd5);
      cyc = 0;
      for (int i = 0; i < 10 && !busy; i++) step(1);
      while (busy && cyc < 50) begin
         cyc++;
         step(1);
      end
      check("t1_cycles", cyc, 10);
      wait_drain("t1", 50);

      // Two engines, two 1-word packets each
`ifdef NTS_TX_ARB_STRICT_PRIORITY_EN
      exp_pkt(0, 2, 1, 4'd8);
      exp_pkt(0, 3, 1, 4'd0);
      exp_pkt(1, 4, 1, 4'd1);
      exp_pkt(1, 5, 1, 4'd7);
`else
      exp_pkt(1, 4, 1, 4'd1);
      exp_pkt(0, 2, 1, 4'd8);
      exp_pkt(1, 5, 1, 4'd7);
      exp_pkt(0, 3, 1, 4'd0);
`endif
      load_pkt(0, 2, 1, 4'd8);
      load_pkt(0, 3, 1, 4'd0);
      load_pkt(1, 4, 1, 4'd1);
      load_pkt(1, 5, 1, 4'd7);
      wait_drain("t2", 100);
      check("t2_errors", err_seen, exp_err);

      // MAC back-pressure on first and second word
      ready = 1'b0;
      exp_pkt(0, 6, 3, 4'd8);
      load_pkt(0, 6, 3, 4'd8);
      wait_valid("t3a", 20);
      step(5);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      wait_valid("t3b", 20);
      step(5);
      ready = 1'b1;
      wait_drain("t3", 50);

      // Overlong packet truncated at MAXW words
      exp_pkt(1, 7, 6, 4'd3);
      load_pkt(1, 7, 6, 4'd3);
      wait_drain("t4", 60);
      check("t4_errors", err_seen, exp_err);

      // Zero-length packet
      exp_pkt(0, 8, 0, 4'd8);
      load_pkt(0, 8, 0, 4'd8);
      wait_drain("t5", 30);
      check("t5_errors", err_seen, exp_err);
      check("rd_en_count", rd_pulses, exp_reads);

      // Async reset while a word is held in SEND
      ready = 1'b0;
      exp_pkt(0, 9, 3, 4'd2);
      load_pkt(0, 9, 3, 4'd2);
      wait_valid("t6", 20);
      step(1);
      rst_n = 1'b0;
      #1;
      check("t6_reset_outputs", {rd_en, pkt_read, valid, data, bytes, last, abort, error, busy}, 0);
      exp_q.delete();
      rel_q.delete();
      exp_pkt(0, 9, 3, 4'd2);
      step(2);
      rst_n = 1'b1;
      ready = 1'b1;
      wait_drain("t6", 60);
      check("final_errors", err_seen, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
